// File: rtl/dmem_arbiter_pkg.sv
// Shared types and port indices for the data-memory arbiter.
package dmem_arbiter_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int CORE = 0;
  localparam int DBG  = 1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick; the pointer remembers the last granted port.
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] gnt,
  output logic [1:0] pick
);

  logic ptr_dbg;

  // On a tie, the port that did not win last time goes next.
  always_comb begin
    pick = req;
    if (req[CORE] && req[DBG])
      pick = ptr_dbg ? 2'b01 : 2'b10;
  end

  // Pointer follows the final grant, so locked debug grants count too.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           ptr_dbg <= 1'b1;
    else if (gnt[DBG])    ptr_dbg <= 1'b1;
    else if (gnt[CORE])   ptr_dbg <= 1'b0;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Core/debug data-memory arbiter with round-robin ties and a bounded debug lock.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 9,
  parameter int LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_lock,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_wr,
  output logic              m_rd,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam int            CW      = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX);

  arb_state_t    state;
  logic [CW-1:0] cnt, cnt_inc;
  logic [1:0]    pick, gnt;

  rr_arb2 u_rr (
    .clk   (clk),
    .reset (reset),
    .req   ({d_req, c_req}),
    .gnt   (gnt),
    .pick  (pick)
  );

  // Grants are gated by reset so nothing reaches memory while it is held.
  always_comb begin
    gnt = (state == LOCKED) ? {d_req, 1'b0} : pick;
    if (!reset) gnt = '0;
  end

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ARB;
      cnt   <= '0;
    end else begin
      case (state)
        ARB: begin
          if (gnt[DBG] && d_lock) begin
            state <= LOCKED;
            cnt   <= CW'(1);
          end
        end
        LOCKED: begin
          if (!d_req) begin
            state <= ARB;
          end else begin
            cnt <= cnt_inc;
            if (!d_lock || (cnt_inc == CNT_MAX && c_req)) state <= ARB;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
    end else begin
      c_rvalid <= gnt[CORE] & ~c_we;
      d_rvalid <= gnt[DBG]  & ~d_we;
    end
  end

  assign c_gnt   = gnt[CORE];
  assign d_gnt   = gnt[DBG];
  assign m_wr    = (gnt[CORE] & c_we)  | (gnt[DBG] & d_we);
  assign m_rd    = (gnt[CORE] & ~c_we) | (gnt[DBG] & ~d_we);
  assign m_addr  = gnt[CORE] ? c_addr  : (gnt[DBG] ? d_addr  : '0);
  assign m_wdata = gnt[CORE] ? c_wdata : (gnt[DBG] ? d_wdata : '0);
  assign c_rdata = m_rdata;
  assign d_rdata = m_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized + directed bench for dmem_arbiter against a transaction-level model.
module tb_dmem_arbiter;

  localparam int DW = 32;
  localparam int AW = 9;
  localparam int LM = 8;

  logic          clk = 1'b0, reset = 1'b0;
  logic          c_req = 1'b0, c_we = 1'b0;
  logic [AW-1:0] c_addr = '0;
  logic [DW-1:0] c_wdata = '0;
  logic          c_gnt, c_rvalid;
  logic [DW-1:0] c_rdata;
  logic          d_req = 1'b0, d_we = 1'b0, d_lock = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          m_wr, m_rd;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata = '0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .LOCK_MAX(LM)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_wr(m_wr), .m_rd(m_rd), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  int checks = 0, failures = 0;

  // Model: lock session flag, grants taken in this session, last winner (1 = debug).
  bit            locked;
  int            lk_n;
  int            last_w;
  bit            e_crv, e_drv, eg_c, eg_d, obs_c, obs_d;
  logic [DW-1:0] rd_val, obs_rd;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    locked = 0; lk_n = 0; last_w = 1; e_crv = 0; e_drv = 0;
  endtask

  task automatic cyc();
    @(negedge clk);
    eg_c = 0; eg_d = 0;
    if (reset) begin
      if (locked)                eg_d = d_req;
      else if (c_req && d_req) begin
        if (last_w == 1) eg_c = 1; else eg_d = 1;
      end else begin
        eg_c = c_req; eg_d = d_req;
      end
    end
    obs_c = c_gnt; obs_d = d_gnt; obs_rd = c_rdata;
    chk("gnt", 64'({c_gnt, d_gnt}), 64'({eg_c, eg_d}));
    chk("strobe", 64'({m_wr, m_rd}),
        64'({(eg_c & c_we) | (eg_d & d_we), (eg_c & !c_we) | (eg_d & !d_we)}));
    chk("m_addr", 64'(m_addr), 64'(eg_c ? c_addr : (eg_d ? d_addr : '0)));
    chk("m_wdata", 64'(m_wdata), 64'(eg_c ? c_wdata : (eg_d ? d_wdata : '0)));
    chk("rvalid", 64'({c_rvalid, d_rvalid}), 64'({e_crv, e_drv}));
    if (e_crv || e_drv) chk("rdata", {c_rdata, d_rdata}, {m_rdata, m_rdata});
    @(posedge clk);
    if (!reset) model_reset();
    else begin
      e_crv = eg_c & !c_we;
      e_drv = eg_d & !d_we;
      if (eg_c) last_w = 0;
      if (eg_d) last_w = 1;
      if (!locked) begin
        if (eg_d && d_lock) begin locked = 1; lk_n = 1; end
      end else if (!d_req) locked = 0;
      else begin
        if (lk_n < LM) lk_n++;
        if (!d_lock || (lk_n == LM && c_req)) locked = 0;
      end
    end
    #1;
    m_rdata = rd_val;
    rd_val  = $urandom;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int dcnt;
    bit seen_c;
    rd_val = $urandom;
    model_reset();
    repeat (2) cyc();
    reset = 1'b1;

    // Core-only read returning DEADBEEF
    c_req = 1; c_we = 0; c_addr = 9'h010; rd_val = 32'hDEADBEEF;
    cyc();
    chk("c030_gnt", 64'(obs_c), 64'd1);
    c_req = 0;
    cyc();
    chk("c030_rdata", 64'(obs_rd), 64'hDEADBEEF);

    // Both reading from reset: alternation, core first
    reset = 0; model_reset(); cyc(); reset = 1;
    c_req = 1; d_req = 1; c_we = 0; d_we = 0; d_lock = 0;
    cyc();
    chk("c031_first", 64'({obs_c, obs_d}), 64'b10);
    repeat (5) cyc();

    // Locked debug write vs a persistent core request
    d_req = 0; cyc();
    d_req = 1; d_we = 1; d_addr = 9'h1FF; d_wdata = 32'h12345678; d_lock = 1;
    dcnt = 0; seen_c = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (!seen_c) begin
        if (obs_d) dcnt++;
        if (obs_c) seen_c = 1;
      end
    end
    chk("c032_dgrants", 64'(dcnt), 64'd8);
    chk("c032_core", 64'(seen_c), 64'd1);

    // Lock with core idle: saturates, no wrap
    d_lock = 0; cyc();
    c_req = 0; d_lock = 1; dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (obs_d) dcnt++;
    end
    chk("c033_dgrants", 64'(dcnt), 64'd12);
    c_req = 1; cyc(); cyc();
    chk("c033_release", 64'({obs_c, obs_d}), 64'b10);

    // Reset mid-lock with a read in flight
    c_req = 0; d_we = 0; d_lock = 1;
    cyc(); cyc();
    reset = 0; model_reset();
    #1;
    chk("c034_imm", 64'({c_gnt, d_gnt, c_rvalid, d_rvalid, m_wr, m_rd}), 64'd0);
    c_req = 1;
    repeat (2) cyc();
    reset = 1; d_lock = 0; c_we = 0;
    cyc();
    chk("c034_tie", 64'({obs_c, obs_d}), 64'b10);
    cyc();

    // Randomized traffic, honouring hold-until-grant
    repeat (400) begin
      if (!c_req || eg_c) begin
        c_req = 1'($urandom_range(0, 1)); c_we = 1'($urandom_range(0, 1));
        c_addr = AW'($urandom); c_wdata = $urandom;
      end
      if (!d_req || eg_d) begin
        d_req = 1'($urandom_range(0, 1)); d_we = 1'($urandom_range(0, 1));
        d_addr = AW'($urandom); d_wdata = $urandom;
      end
      d_lock = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 63) == 0) begin
        reset = 0; model_reset(); cyc(); reset = 1;
      end
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters: DATA_W, default 32, data width; ADDR_W, default 9, word address width; LOCK_MAX, default 8, maximum consecutive locked debug grants.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 c_req, c_we  in  1,1  core access request; core write enable (0 = read).
REQ-005 c_addr, c_wdata  in  ADDR_W, DATA_W  core address; core write data.
REQ-006 c_gnt, c_rvalid  out  1,1  core access granted this cycle; core read data valid.
REQ-007 c_rdata  out  DATA_W  core read data.
REQ-008 d_req, d_we, d_lock  in  1,1,1  debug/loader request; write enable; lock request for atomic sequences.
REQ-009 d_addr, d_wdata  in  ADDR_W, DATA_W  debug address; debug write data.
REQ-010 d_gnt, d_rvalid  out  1,1  debug access granted; debug read data valid.
REQ-011 d_rdata  out  DATA_W  debug read data.
REQ-012 m_wr, m_rd  out  1,1  memory write strobe; memory read strobe (the wr/rd pair of the data memory).
REQ-013 m_addr, m_wdata  out  ADDR_W, DATA_W  memory address; memory write data.
REQ-014 m_rdata  in  DATA_W  memory read data, valid one cycle after m_rd.

Function
REQ-015 At most one of c_gnt and d_gnt SHALL be high in any cycle; a grant is combinational in the same cycle as the request.
REQ-016 A requester SHALL hold req, we, addr and wdata stable until it sees its gnt; the access completes in the granted cycle.
REQ-017 m_addr, m_wdata, m_wr = we and m_rd = ~we SHALL come from the granted port; with no grant, m_wr = m_rd = 0 and m_addr/m_wdata = 0.
REQ-018 x_rvalid SHALL rise exactly one cycle after a granted read by port x, and never after a write; c_rdata = d_rdata = m_rdata.
REQ-019 FSM state ARB: if only one port requests, grant it. If both request, grant the port not granted last (round-robin pointer), then update the pointer to the granted port.
REQ-020 ARB -> LOCKED when d_gnt and d_lock are both high; the lock counter loads 1.
REQ-021 LOCKED: d_req SHALL be granted every cycle regardless of c_req; each d_gnt increments the counter.
REQ-022 LOCKED -> ARB when d_lock falls, or when d_req falls. Also when the counter reaches LOCK_MAX while c_req is high; the next cycle then SHALL grant core if c_req is still high.
REQ-023 In LOCKED with d_req low, no grant is issued in that cycle; the transition to ARB happens at that edge.
REQ-024 Counter width SHALL be $clog2(LOCK_MAX+1) bits; it saturates at LOCK_MAX when c_req is low and does not wrap.
REQ-025 The round-robin pointer also updates on single-requester grants and during LOCKED (pointer = debug).

Reset
REQ-026 While reset is low: state = ARB, pointer = debug (core wins the first tie), counter = 0, rvalid registers = 0.
REQ-027 While reset is low, all gnt, rvalid, m_wr and m_rd outputs SHALL be 0, including mid-lock or with a read in flight; no pending rvalid SHALL emerge after release.

Structure
REQ-028 A shared package SHALL hold the FSM state enum (ARB, LOCKED) and the port-index constants CORE = 0 and DBG = 1.
REQ-029 One sub-module, rr_arb2 (2-way round-robin pick plus pointer register), is natural; the lock FSM and the muxes stay in the top module.

Verification
REQ-030 Core-only read at addr 0x010, memory returning 0xDEADBEEF -> c_gnt same cycle, m_rd = 1, c_rvalid next cycle with c_rdata = 0xDEADBEEF.
REQ-031 Both request reads continuously from reset -> grants alternate core, debug, core, ...; d_rvalid never follows a core grant.
REQ-032 Debug write 0x12345678 to 0x1FF with d_lock held for 12 cycles, c_req high throughout -> 8 debug grants, then 1 core grant, then LOCKED re-entered on the next granted d_lock.
REQ-033 Lock held with c_req low -> debug granted all 12 cycles; counter saturates at 8.
REQ-034 reset asserted the cycle after a granted read, mid-lock -> all outputs 0 immediately, no rvalid after release, and the first tie after release goes to core.
